frame_state_latch: RTL and testbench
====================================

Name: frame_state_latch

Overview:
- Sits directly upstream of the VGA controller and pixel generator, in the pixel clock domain.
- Accepts elevator status updates (destination, people_data, sim_state) from the elevator FSM through a valid/ready handshake and holds them in a one-entry pending buffer.
- Commits the pending entry to the display-facing outputs only at the start of vertical blanking, so the screen never tears mid-frame.
- Also produces frame-rate animation state: the displayed car floor steps toward the destination, plus a frame counter and a blink signal.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- STEP_FRAMES, 16, frames per one-floor step of the displayed car (must be ≥1).
- BLINK_BIT, 4, frame_count bit that drives blink.

Ports:
- pixel_clk  in  1  pixel clock, all state on its rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- horiz_count  in  10  current pixel column from the VGA timing counters.
- vert_count  in  10  current line from the VGA timing counters.
- upd_valid  in  1  update offered.
- upd_ready  out  1  pending buffer empty.
- upd_destination  in  8  one-hot target floor.
- upd_people_data  in  26  passenger status bits.
- upd_sim_state  in  2  simulation state.
- destination  out  8  committed destination.
- people_data  out  26  committed passenger status.
- sim_state  out  2  committed simulation state.
- car_floor  out  3  animated displayed floor.
- moving  out  1  car_floor differs from the target floor.
- frame_start  out  1  one-cycle pulse, one cycle after the commit point.
- frame_count  out  8  frames elapsed, wraps.
- blink  out  1  frame_count[BLINK_BIT].

Behaviour:
- Reset (n_reset=0, asynchronous): all registers are 0.
  - destination, people_data, sim_state, car_floor, frame_count, step counter and frame_start are 0.
  - The pending buffer is empty, so upd_ready=1, moving=0, blink=0.
- Handshake:
  - upd_ready = !pending_full; this is combinational from a register.
  - A transfer occurs when upd_valid && upd_ready. The three upd_* fields are captured into pending and pending_full is set.
  - upd_valid without upd_ready has no effect. The source must hold its data.
- Commit point (CP): the single cycle where vert_count==V_ACTIVE && horiz_count==0.
  - At CP, if pending_full: the outputs load the pending fields and pending_full clears. upd_ready is 1 on the next cycle.
  - At CP, if pending is empty: the outputs hold.
  - A transfer in the CP cycle (pending empty) lands in pending and commits at the next CP. There is no bypass, so worst-case latency is one frame.
- frame_start is registered, high for exactly the cycle after CP.
- frame_count increments at every CP and wraps 255→0.
- Target floor: the index of the lowest set bit of the committed destination, sampled before any commit in the same cycle.
  - A destination of 0 means no target: car_floor holds and the step counter clears.
- Animation, evaluated at CP only:
  - If car_floor==target, the step counter clears.
  - Otherwise the step counter increments. When it reaches STEP_FRAMES-1, car_floor moves ±1 toward the target and the counter clears.
  - A target change mid-approach keeps the counter value and the direction re-evaluates.
- Pause: a committed sim_state==2'b11 freezes the step counter, car_floor, frame_count and blink. The CP commit itself still occurs, and frame_start still pulses.
- moving = (destination!=0) && (car_floor!=target). It is combinational from registers.
- Counters outside the frame (horiz_count ≥ H_ACTIVE+...) are tolerated; only equality with the CP is decoded.
- Reset mid-frame or mid-handshake discards any pending entry, and the next transfer starts fresh.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants H_ACTIVE, V_ACTIVE and the porch/sync values;
  - the sim_state_t enum, with 2'b11 = SIM_PAUSED;
  - the struct elev_status_t {destination, people_data, sim_state}, used for both pending and committed state.
- Sub-module car_animator: the target encode, step counter and car_floor/moving logic, with inputs CP, paused and destination.

Test Plan:
- Reset mid-frame with pending full -> all outputs 0, upd_ready=1 while n_reset=0 and after release.
- Transfer at (vert=100, h=5) with dest=8'h10, people=26'h3, state=2'b01 -> upd_ready=0 next cycle; outputs unchanged until (480,0); values appear on the cycle after CP; frame_start pulses once; upd_ready=1.
- Second upd_valid while pending full -> no capture; the first value commits; the second transfers after CP and commits at the following CP.
- Transfer exactly in the CP cycle with pending empty -> committed at the next CP, not this one.
- dest=8'h20, car_floor=0, STEP_FRAMES=16 -> car_floor reaches 5 after 80 CPs; moving=1 throughout, then 0; 8'h01 mid-travel reverses direction.
- sim_state=2'b11 committed -> frame_count, blink and car_floor frozen across 10 frames; frame_count wraps 255→0 when unpaused.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and elevator status types for the display path.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    SIM_IDLE   = 2'b00,
    SIM_RUN    = 2'b01,
    SIM_STOP   = 2'b10,
    SIM_PAUSED = 2'b11
  } sim_state_t;

  typedef struct packed {
    logic [7:0]  destination;
    logic [25:0] people_data;
    sim_state_t  sim_state;
  } elev_status_t;

  // One-hot destination to floor index; the lowest set bit wins.
  function automatic logic [2:0] lowest_set_idx(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/car_animator.sv
// Frame-rate animation of the displayed car: steps car_floor one floor per
// STEP_FRAMES commit points toward the floor encoded by the committed destination.
module car_animator
  import vga_pkg::*;
#(
  parameter int STEP_FRAMES = 16
) (
  input  logic       pixel_clk_i,
  input  logic       n_reset_i,
  input  logic       cp_i,
  input  logic       paused_i,
  input  logic [7:0] destination_i,
  output logic [2:0] car_floor_o,
  output logic       moving_o
);

  localparam int STEP_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_FRAMES - 1);

  logic [STEP_W-1:0] step_q, step_d;
  logic [2:0]        car_q, car_d;
  logic [2:0]        target_s;
  logic              has_target_s;

  assign target_s     = lowest_set_idx(destination_i);
  assign has_target_s = (destination_i != 8'd0);
  assign car_floor_o  = car_q;
  assign moving_o     = has_target_s && (car_q != target_s);

  // Next-state for the step counter and displayed floor at each commit point.
  always_comb begin
    step_d = step_q;
    car_d  = car_q;
    if (cp_i && !paused_i) begin
      if (!has_target_s || (car_q == target_s)) begin
        step_d = {STEP_W{1'b0}};
      end else if (step_q == STEP_LAST) begin
        step_d = {STEP_W{1'b0}};
        if (target_s > car_q) begin
          car_d = car_q + 3'd1;
        end else begin
          car_d = car_q - 3'd1;
        end
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end else begin
      step_d = step_q;
      car_d  = car_q;
    end
  end

  // Animation state registers.
  always_ff @(posedge pixel_clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      step_q <= {STEP_W{1'b0}};
      car_q  <= 3'd0;
    end else begin
      step_q <= step_d;
      car_q  <= car_d;
    end
  end

endmodule

// File: rtl/frame_state_latch.sv
// Buffers elevator status updates and commits them to the display outputs only
// at the start of vertical blanking, plus frame counter, blink and car animation.
module frame_state_latch
  import vga_pkg::*;
#(
  parameter int STEP_FRAMES = 16,
  parameter int BLINK_BIT   = 4
) (
  input  logic        pixel_clk,
  input  logic        n_reset,
  input  logic [9:0]  horiz_count,
  input  logic [9:0]  vert_count,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [7:0]  upd_destination,
  input  logic [25:0] upd_people_data,
  input  logic [1:0]  upd_sim_state,
  output logic [7:0]  destination,
  output logic [25:0] people_data,
  output logic [1:0]  sim_state,
  output logic [2:0]  car_floor,
  output logic        moving,
  output logic        frame_start,
  output logic [7:0]  frame_count,
  output logic        blink
);

  elev_status_t pending_q, pending_d;
  elev_status_t committed_q, committed_d;
  logic         pending_full_q, pending_full_d;
  logic         frame_start_q;
  logic [7:0]   frame_count_q, frame_count_d;
  logic         cp_s, xfer_s, paused_s;

  // Only exact equality is decoded, so out-of-frame counter values are harmless.
  assign cp_s     = (vert_count == 10'(V_ACTIVE)) && (horiz_count == 10'd0);
  assign xfer_s   = upd_valid && !pending_full_q;
  assign paused_s = (committed_q.sim_state == SIM_PAUSED);

  assign upd_ready   = !pending_full_q;
  assign destination = committed_q.destination;
  assign people_data = committed_q.people_data;
  assign sim_state   = committed_q.sim_state;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign blink       = frame_count_q[BLINK_BIT];

  // Pending capture and commit; both cannot occur together since capture needs an empty buffer.
  always_comb begin
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    committed_d    = committed_q;
    if (xfer_s) begin
      pending_d.destination = upd_destination;
      pending_d.people_data = upd_people_data;
      pending_d.sim_state   = sim_state_t'(upd_sim_state);
      pending_full_d        = 1'b1;
    end else if (cp_s && pending_full_q) begin
      committed_d    = pending_q;
      pending_full_d = 1'b0;
    end else begin
      pending_full_d = pending_full_q;
    end
  end

  // Frame counter advances once per frame unless the committed state is paused.
  always_comb begin
    frame_count_d = frame_count_q;
    if (cp_s && !paused_s) begin
      frame_count_d = frame_count_q + 8'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Status, handshake and frame registers.
  always_ff @(posedge pixel_clk or negedge n_reset) begin
    if (!n_reset) begin
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      committed_q    <= '0;
      frame_start_q  <= 1'b0;
      frame_count_q  <= 8'd0;
    end else begin
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      committed_q    <= committed_d;
      frame_start_q  <= cp_s;
      frame_count_q  <= frame_count_d;
    end
  end

  // Animation sees the destination committed before this cycle's commit.
  car_animator #(
    .STEP_FRAMES(STEP_FRAMES)
  ) u_car_animator (
    .pixel_clk_i  (pixel_clk),
    .n_reset_i    (n_reset),
    .cp_i         (cp_s),
    .paused_i     (paused_s),
    .destination_i(committed_q.destination),
    .car_floor_o  (car_floor),
    .moving_o     (moving)
  );

endmodule

// File: tb/tb_frame_state_latch.sv
// Directed self-checking bench for frame_state_latch; frames are compressed by
// driving the VGA counters straight to the commit point and away again.
module tb_frame_state_latch;

  logic        pixel_clk;
  logic        n_reset;
  logic [9:0]  horiz_count;
  logic [9:0]  vert_count;
  logic        upd_valid;
  logic        upd_ready;
  logic [7:0]  upd_destination;
  logic [25:0] upd_people_data;
  logic [1:0]  upd_sim_state;
  logic [7:0]  destination;
  logic [25:0] people_data;
  logic [1:0]  sim_state;
  logic [2:0]  car_floor;
  logic        moving;
  logic        frame_start;
  logic [7:0]  frame_count;
  logic        blink;

  int checks = 0;
  int errors = 0;

  frame_state_latch dut (
    .pixel_clk      (pixel_clk),
    .n_reset        (n_reset),
    .horiz_count    (horiz_count),
    .vert_count     (vert_count),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_destination(upd_destination),
    .upd_people_data(upd_people_data),
    .upd_sim_state  (upd_sim_state),
    .destination    (destination),
    .people_data    (people_data),
    .sim_state      (sim_state),
    .car_floor      (car_floor),
    .moving         (moving),
    .frame_start    (frame_start),
    .frame_count    (frame_count),
    .blink          (blink)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic go_away();
    vert_count  = 10'd0;
    horiz_count = 10'd1;
  endtask

  task automatic do_cp();
    vert_count  = 10'd480;
    horiz_count = 10'd0;
    tick();
    go_away();
  endtask

  task automatic offer(input logic [7:0] d, input logic [25:0] p, input logic [1:0] s);
    upd_valid = 1'b1; upd_destination = d; upd_people_data = p; upd_sim_state = s;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic apply_reset();
    upd_valid = 1'b0;
    go_away();
    n_reset = 1'b0;
    tick();
    tick();
    n_reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    offer(8'h01, 26'h3FFFFFF, 2'b10);
    do_cp();
    offer(8'h40, 26'h1234567, 2'b01);
    vert_count = 10'd100; horiz_count = 10'd5;
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_ready got %0b want 0", upd_ready); end
    checks++; if (destination !== 8'h01) begin errors++; $display("FAIL rst_pre_dest got %h want 01", destination); end
    #2 n_reset = 1'b0;
    #1;
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b want 1", upd_ready); end
    checks++; if ({destination, people_data, sim_state} !== 36'd0) begin errors++; $display("FAIL rst_status got %h want 0", {destination, people_data, sim_state}); end
    checks++; if ({car_floor, moving, frame_start, frame_count, blink} !== 14'd0) begin errors++; $display("FAIL rst_anim got %h want 0", {car_floor, moving, frame_start, frame_count, blink}); end
    tick();
    n_reset = 1'b1;
    go_away();
    tick();
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL rst_post_ready got %0b want 1", upd_ready); end
    do_cp();
    checks++; if (destination !== 8'h00) begin errors++; $display("FAIL rst_discard got %h want 00", destination); end
    checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL rst_fc got %0d want 1", frame_count); end
  endtask

  task automatic test_transfer();
    apply_reset();
    vert_count = 10'd100; horiz_count = 10'd5;
    upd_valid = 1'b1; upd_destination = 8'h10; upd_people_data = 26'h3; upd_sim_state = 2'b01;
    tick();
    upd_valid = 1'b0;
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL xfer_ready got %0b want 0", upd_ready); end
    vert_count = 10'd479; horiz_count = 10'd639;
    tick();
    vert_count = 10'd480; horiz_count = 10'd1;
    tick();
    checks++; if (destination !== 8'h00) begin errors++; $display("FAIL xfer_hold got %h want 00", destination); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL xfer_fs_early got %0b want 0", frame_start); end
    do_cp();
    checks++; if ({destination, people_data, sim_state} !== {8'h10, 26'h3, 2'b01}) begin errors++; $display("FAIL xfer_commit got %h want %h", {destination, people_data, sim_state}, {8'h10, 26'h3, 2'b01}); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL xfer_fs got %0b want 1", frame_start); end
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL xfer_ready_after got %0b want 1", upd_ready); end
    checks++; if (moving !== 1'b1) begin errors++; $display("FAIL xfer_moving got %0b want 1", moving); end
    tick();
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL xfer_fs_once got %0b want 0", frame_start); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    offer(8'h02, 26'h2AAAAAA, 2'b01);
    upd_valid = 1'b1; upd_destination = 8'h04; upd_people_data = 26'h1555555; upd_sim_state = 2'b10;
    tick();
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL b2b_blocked got %0b want 0", upd_ready); end
    do_cp();
    checks++; if ({destination, people_data} !== {8'h02, 26'h2AAAAAA}) begin errors++; $display("FAIL b2b_first got %h want %h", {destination, people_data}, {8'h02, 26'h2AAAAAA}); end
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL b2b_free got %0b want 1", upd_ready); end
    tick();
    upd_valid = 1'b0;
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_cap got %0b want 0", upd_ready); end
    checks++; if (destination !== 8'h02) begin errors++; $display("FAIL b2b_hold got %h want 02", destination); end
    do_cp();
    checks++; if ({destination, people_data, sim_state} !== {8'h04, 26'h1555555, 2'b10}) begin errors++; $display("FAIL b2b_second got %h want %h", {destination, people_data, sim_state}, {8'h04, 26'h1555555, 2'b10}); end
  endtask

  task automatic test_cp_transfer();
    apply_reset();
    vert_count = 10'd480; horiz_count = 10'd0;
    upd_valid = 1'b1; upd_destination = 8'h08; upd_people_data = 26'h5; upd_sim_state = 2'b01;
    tick();
    upd_valid = 1'b0;
    go_away();
    checks++; if (destination !== 8'h00) begin errors++; $display("FAIL cpx_no_bypass got %h want 00", destination); end
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL cpx_ready got %0b want 0", upd_ready); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL cpx_fs got %0b want 1", frame_start); end
    do_cp();
    checks++; if (destination !== 8'h08) begin errors++; $display("FAIL cpx_commit got %h want 08", destination); end
    checks++; if (frame_count !== 8'd2) begin errors++; $display("FAIL cpx_fc got %0d want 2", frame_count); end
  endtask

  task automatic test_animation();
    int not_moving;
    not_moving = 0;
    apply_reset();
    offer(8'h20, 26'h0, 2'b01);
    do_cp();
    checks++; if ({car_floor, moving} !== {3'd0, 1'b1}) begin errors++; $display("FAIL anim_start got %h want 1", {car_floor, moving}); end
    for (int i = 1; i <= 80; i++) begin
      do_cp();
      if (i < 80 && moving !== 1'b1) not_moving++;
      if (i == 15) begin
        checks++; if (car_floor !== 3'd0) begin errors++; $display("FAIL anim_cp15 got %0d want 0", car_floor); end
      end else if (i == 16) begin
        checks++; if (car_floor !== 3'd1) begin errors++; $display("FAIL anim_cp16 got %0d want 1", car_floor); end
      end else if (i == 79) begin
        checks++; if (car_floor !== 3'd4) begin errors++; $display("FAIL anim_cp79 got %0d want 4", car_floor); end
      end
    end
    checks++; if (not_moving !== 0) begin errors++; $display("FAIL anim_moving_gaps got %0d want 0", not_moving); end
    checks++; if ({car_floor, moving} !== {3'd5, 1'b0}) begin errors++; $display("FAIL anim_arrive got %h want a", {car_floor, moving}); end
    offer(8'h80, 26'h0, 2'b01);
    do_cp();
    for (int i = 1; i <= 20; i++) do_cp();
    checks++; if (car_floor !== 3'd6) begin errors++; $display("FAIL anim_up got %0d want 6", car_floor); end
    offer(8'h01, 26'h0, 2'b01);
    do_cp();
    for (int i = 1; i <= 10; i++) do_cp();
    checks++; if (car_floor !== 3'd6) begin errors++; $display("FAIL anim_rev_wait got %0d want 6", car_floor); end
    do_cp();
    checks++; if ({car_floor, moving} !== {3'd5, 1'b1}) begin errors++; $display("FAIL anim_rev got %h want b", {car_floor, moving}); end
  endtask

  task automatic test_pause();
    int frozen_bad;
    frozen_bad = 0;
    apply_reset();
    for (int i = 0; i < 16; i++) do_cp();
    checks++; if ({frame_count, blink} !== {8'd16, 1'b1}) begin errors++; $display("FAIL pause_pre got %h want 21", {frame_count, blink}); end
    offer(8'h04, 26'h0, 2'b11);
    do_cp();
    checks++; if ({sim_state, frame_count} !== {2'b11, 8'd17}) begin errors++; $display("FAIL pause_commit got %h want 311", {sim_state, frame_count}); end
    for (int i = 0; i < 10; i++) begin
      do_cp();
      if (frame_start !== 1'b1 || frame_count !== 8'd17 || blink !== 1'b1 || car_floor !== 3'd0) frozen_bad++;
    end
    checks++; if (frozen_bad !== 0) begin errors++; $display("FAIL pause_frozen got %0d bad frames want 0", frozen_bad); end
    offer(8'h00, 26'h0, 2'b01);
    do_cp();
    checks++; if (frame_count !== 8'd17) begin errors++; $display("FAIL pause_unpause got %0d want 17", frame_count); end
    for (int i = 0; i < 238; i++) do_cp();
    checks++; if (frame_count !== 8'd255) begin errors++; $display("FAIL pause_255 got %0d want 255", frame_count); end
    do_cp();
    checks++; if ({frame_count, blink} !== {8'd0, 1'b0}) begin errors++; $display("FAIL pause_wrap got %h want 0", {frame_count, blink}); end
  endtask

  initial begin
    n_reset = 1'b0;
    upd_valid = 1'b0;
    upd_destination = 8'h00;
    upd_people_data = 26'h0;
    upd_sim_state = 2'b00;
    horiz_count = 10'd0;
    vert_count = 10'd0;
    #1;
    checks++; if ({upd_ready, destination, frame_count, car_floor, frame_start} !== {1'b1, 8'h00, 8'h00, 3'd0, 1'b0}) begin errors++; $display("FAIL init_reset got %h", {upd_ready, destination, frame_count, car_floor, frame_start}); end
    test_reset();
    test_transfer();
    test_back_to_back();
    test_cp_transfer();
    test_animation();
    test_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
